// File: rtl/ddr2_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ddr2_cmd_decoder
// Description : DDR2 command-bus receiver. It decodes commands, tracks the
//               open/closed state and open row of each bank, captures MR0,
//               and flags tRCD/tRP/tRFC and bank-state protocol errors.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr2_cmd_decoder #(
    parameter  int BA_BITS   = 3,
    parameter  int ADDR_BITS = 14,
    parameter  int TRCD      = 3,
    parameter  int TRP       = 3,
    parameter  int TRFC      = 26,
    parameter  int TAP       = 5,
    localparam int NUM_BANKS = 2**BA_BITS
) (
    input  logic                           ck,
    input  logic                           rst,
    input  logic                           cke,
    input  logic                           cs_n,
    input  logic                           ras_n,
    input  logic                           cas_n,
    input  logic                           we_n,
    input  logic [BA_BITS-1:0]             ba,
    input  logic [ADDR_BITS-1:0]           addr,
    input  logic                           err_clr,
    output logic                           cmd_valid,
    output logic [2:0]                     cmd_code,
    output logic [BA_BITS-1:0]             cmd_ba,
    output logic [ADDR_BITS-1:0]           cmd_addr,
    output logic [NUM_BANKS-1:0]           bank_open,
    output logic                           row_hit,
    output logic [2:0]                     mr_bl,
    output logic [2:0]                     mr_cl,
    output logic                           mr_valid,
    output logic [5:0]                     err,
    output logic [NUM_BANKS*ADDR_BITS-1:0] bank_row
);

    localparam int c_MAX_A = (TRCD > TRP)    ? TRCD    : TRP;
    localparam int c_MAX_B = (TAP > TRFC)    ? TAP     : TRFC;
    localparam int c_MAX_T = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_CNT_W = $clog2(c_MAX_T) + 1;

    localparam logic [c_CNT_W-1:0] c_TRCD_LD = c_CNT_W'(TRCD - 1);
    localparam logic [c_CNT_W-1:0] c_TRP_LD  = c_CNT_W'(TRP - 1);
    localparam logic [c_CNT_W-1:0] c_TRFC_LD = c_CNT_W'(TRFC - 1);
    localparam logic [c_CNT_W-1:0] c_TAP_LD  = c_CNT_W'(TAP - 1);
    localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

    localparam logic [2:0] c_CMD_NOP  = 3'd0;
    localparam logic [2:0] c_CMD_ACT  = 3'd1;
    localparam logic [2:0] c_CMD_RD   = 3'd2;
    localparam logic [2:0] c_CMD_WR   = 3'd3;
    localparam logic [2:0] c_CMD_PRE  = 3'd4;
    localparam logic [2:0] c_CMD_REF  = 3'd5;
    localparam logic [2:0] c_CMD_LMR  = 3'd6;
    localparam logic [2:0] c_CMD_RSVD = 3'd7;

    logic [2:0]           w_code;
    logic                 w_valid;
    logic                 w_act, w_rw, w_pre, w_ref, w_lmr, w_rsvd;
    logic [NUM_BANKS-1:0] w_bank_open;
    logic [NUM_BANKS-1:0] w_trcd_nz;
    logic [NUM_BANKS-1:0] w_trp_nz;
    logic [5:0]           w_err_set;

    logic                 r_cmd_valid;
    logic [2:0]           r_cmd_code;
    logic [BA_BITS-1:0]   r_cmd_ba;
    logic [ADDR_BITS-1:0] r_cmd_addr;
    logic                 r_row_hit;
    logic [2:0]           r_mr_bl;
    logic [2:0]           r_mr_cl;
    logic                 r_mr_valid;
    logic [5:0]           r_err;
    logic [c_CNT_W-1:0]   r_trfc_cnt;

    always_comb begin
        w_code = c_CMD_NOP;
        case ({ras_n, cas_n, we_n})
            3'b000:  w_code = c_CMD_LMR;
            3'b001:  w_code = c_CMD_REF;
            3'b010:  w_code = c_CMD_PRE;
            3'b011:  w_code = c_CMD_ACT;
            3'b100:  w_code = c_CMD_WR;
            3'b101:  w_code = c_CMD_RD;
            3'b110:  w_code = c_CMD_RSVD;
            default: w_code = c_CMD_NOP;
        endcase
    end

    // Power-down (cke low) and deselect both suppress the command entirely.
    assign w_valid = cke && !cs_n && (w_code != c_CMD_NOP);
    assign w_act   = w_valid && (w_code == c_CMD_ACT);
    assign w_rw    = w_valid && ((w_code == c_CMD_RD) || (w_code == c_CMD_WR));
    assign w_pre   = w_valid && (w_code == c_CMD_PRE);
    assign w_ref   = w_valid && (w_code == c_CMD_REF);
    assign w_lmr   = w_valid && (w_code == c_CMD_LMR);
    assign w_rsvd  = w_valid && (w_code == c_CMD_RSVD);

    // Checks use the bank state held before this edge.
    always_comb begin
        w_err_set    = '0;
        w_err_set[0] = w_act && w_bank_open[ba];
        w_err_set[1] = w_rw  && !w_bank_open[ba];
        w_err_set[2] = w_rw  && w_trcd_nz[ba];
        w_err_set[3] = w_act && w_trp_nz[ba];
        w_err_set[4] = w_ref && (|w_bank_open);
        w_err_set[5] = w_rsvd || (w_valid && (r_trfc_cnt != '0));
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic                 r_open;
        logic [ADDR_BITS-1:0] r_row;
        logic [c_CNT_W-1:0]   r_trcd;
        logic [c_CNT_W-1:0]   r_trp;
        logic                 w_sel;

        assign w_sel = (ba == BA_BITS'(b));

        always_ff @(posedge ck) begin
            if (rst) begin
                r_open <= 1'b0;
                r_row  <= '0;
                r_trcd <= '0;
                r_trp  <= '0;
            end else begin
                r_trcd <= (r_trcd != '0) ? r_trcd - c_ONE : '0;
                r_trp  <= (r_trp  != '0) ? r_trp  - c_ONE : '0;
                if (w_act && w_sel) begin
                    r_open <= 1'b1;
                    r_row  <= addr;
                    r_trcd <= c_TRCD_LD;
                end
                if (w_rw && w_sel && addr[10]) begin
                    r_open <= 1'b0;
                    r_trp  <= c_TAP_LD;
                end
                // Precharging an already closed bank leaves its timer alone.
                if (w_pre && (addr[10] || w_sel) && r_open) begin
                    r_open <= 1'b0;
                    r_trp  <= c_TRP_LD;
                end
            end
        end

        assign w_bank_open[b] = r_open;
        assign w_trcd_nz[b]   = |r_trcd;
        assign w_trp_nz[b]    = |r_trp;
        assign bank_row[b*ADDR_BITS +: ADDR_BITS] = r_row;
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            r_cmd_valid <= 1'b0;
            r_cmd_code  <= c_CMD_NOP;
            r_cmd_ba    <= '0;
            r_cmd_addr  <= '0;
            r_row_hit   <= 1'b0;
            r_mr_bl     <= '0;
            r_mr_cl     <= '0;
            r_mr_valid  <= 1'b0;
            r_err       <= '0;
            r_trfc_cnt  <= '0;
        end else begin
            r_cmd_valid <= w_valid;
            r_row_hit   <= w_rw && w_bank_open[ba];
            r_trfc_cnt  <= (r_trfc_cnt != '0) ? r_trfc_cnt - c_ONE : '0;
            if (w_valid) begin
                r_cmd_code <= w_code;
                r_cmd_ba   <= ba;
                r_cmd_addr <= addr;
            end
            if (w_ref) begin
                r_trfc_cnt <= c_TRFC_LD;
            end
            if (w_lmr && (ba == '0)) begin
                r_mr_bl    <= addr[2:0];
                r_mr_cl    <= addr[6:4];
                r_mr_valid <= 1'b1;
            end
            // New violations win over a simultaneous clear.
            r_err <= (r_err & ~{6{err_clr}}) | w_err_set;
        end
    end

    assign cmd_valid = r_cmd_valid;
    assign cmd_code  = r_cmd_code;
    assign cmd_ba    = r_cmd_ba;
    assign cmd_addr  = r_cmd_addr;
    assign bank_open = w_bank_open;
    assign row_hit   = r_row_hit;
    assign mr_bl     = r_mr_bl;
    assign mr_cl     = r_mr_cl;
    assign mr_valid  = r_mr_valid;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ddr2_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr2_cmd_decoder
// Description : Directed self-checking bench for ddr2_cmd_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr2_cmd_decoder;

    localparam logic [2:0] LMR = 3'b000;
    localparam logic [2:0] REF = 3'b001;
    localparam logic [2:0] PRE = 3'b010;
    localparam logic [2:0] ACT = 3'b011;
    localparam logic [2:0] WR  = 3'b100;
    localparam logic [2:0] RD  = 3'b101;
    localparam logic [2:0] RSV = 3'b110;
    localparam logic [2:0] NOP = 3'b111;

    logic         ck = 1'b0;
    logic         rst = 1'b1;
    logic         cke = 1'b1;
    logic         cs_n = 1'b1;
    logic         ras_n = 1'b1;
    logic         cas_n = 1'b1;
    logic         we_n = 1'b1;
    logic [2:0]   ba = '0;
    logic [13:0]  addr = '0;
    logic         err_clr = 1'b0;
    logic         cmd_valid;
    logic [2:0]   cmd_code;
    logic [2:0]   cmd_ba;
    logic [13:0]  cmd_addr;
    logic [7:0]   bank_open;
    logic         row_hit;
    logic [2:0]   mr_bl;
    logic [2:0]   mr_cl;
    logic         mr_valid;
    logic [5:0]   err;
    logic [111:0] bank_row;

    int vectors = 0;
    int miscompares = 0;

    ddr2_cmd_decoder dut (
        .ck(ck), .rst(rst), .cke(cke), .cs_n(cs_n), .ras_n(ras_n),
        .cas_n(cas_n), .we_n(we_n), .ba(ba), .addr(addr), .err_clr(err_clr),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ba(cmd_ba),
        .cmd_addr(cmd_addr), .bank_open(bank_open), .row_hit(row_hit),
        .mr_bl(mr_bl), .mr_cl(mr_cl), .mr_valid(mr_valid), .err(err),
        .bank_row(bank_row)
    );

    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one command for one rising edge, then settle just past the edge.
    task automatic drive(input logic [2:0] rcw, input logic [2:0] b, input logic [13:0] a);
        cs_n = 1'b0;
        {ras_n, cas_n, we_n} = rcw;
        ba   = b;
        addr = a;
        @(posedge ck);
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) drive(NOP, 3'd0, 14'd0);
    endtask

    task automatic clr();
        err_clr = 1'b1;
        drive(NOP, 3'd0, 14'd0);
        err_clr = 1'b0;
        chk("err_clr", 32'(err), 32'h0);
    endtask

    initial begin
        // Reset, NOPs and deselect
        @(posedge ck); @(posedge ck); #1;
        rst = 1'b0;
        chk("rst cmd_valid", 32'(cmd_valid), 32'h0);
        chk("rst bank_open", 32'(bank_open), 32'h0);
        chk("rst err", 32'(err), 32'h0);
        chk("rst mr_valid", 32'(mr_valid), 32'h0);
        nops(2);
        chk("nop cmd_valid", 32'(cmd_valid), 32'h0);
        cs_n = 1'b1; {ras_n, cas_n, we_n} = ACT; ba = 3'd1;
        @(posedge ck); #1;
        chk("deselect cmd_valid", 32'(cmd_valid), 32'h0);
        chk("deselect bank_open", 32'(bank_open), 32'h0);

        // Mode register load
        drive(LMR, 3'd0, 14'h0032);
        chk("lmr cmd_valid", 32'(cmd_valid), 32'h1);
        chk("lmr cmd_code", 32'(cmd_code), 32'h6);
        chk("lmr mr_bl", 32'(mr_bl), 32'h2);
        chk("lmr mr_cl", 32'(mr_cl), 32'h3);
        chk("lmr mr_valid", 32'(mr_valid), 32'h1);
        drive(LMR, 3'd1, 14'h0075);
        chk("emr cmd_ba", 32'(cmd_ba), 32'h1);
        chk("emr mr_bl", 32'(mr_bl), 32'h2);
        chk("emr mr_cl", 32'(mr_cl), 32'h3);

        // ACT -> READ at tRCD and at tRCD-1
        drive(ACT, 3'd2, 14'h01A5);
        chk("act cmd_code", 32'(cmd_code), 32'h1);
        chk("act bank_open", 32'(bank_open), 32'h04);
        chk("act row", 32'(bank_row[2*14 +: 14]), 32'h01A5);
        nops(2);
        drive(RD, 3'd2, 14'h0010);
        chk("rd cmd_code", 32'(cmd_code), 32'h2);
        chk("rd cmd_addr", 32'(cmd_addr), 32'h0010);
        chk("rd row_hit", 32'(row_hit), 32'h1);
        chk("rd err", 32'(err), 32'h0);
        drive(PRE, 3'd2, 14'h0000);
        chk("pre bank_open", 32'(bank_open), 32'h0);
        nops(2);
        drive(ACT, 3'd2, 14'h0077);
        chk("act after trp err", 32'(err), 32'h0);
        nops(1);
        drive(RD, 3'd2, 14'h0000);
        chk("trcd err", 32'(err), 32'h04);
        clr();

        // ACT to open bank, PRE -> ACT inside tRP
        drive(ACT, 3'd1, 14'h0005);
        chk("act b1 err", 32'(err), 32'h0);
        drive(ACT, 3'd1, 14'h0006);
        chk("act open err", 32'(err), 32'h01);
        clr();
        drive(PRE, 3'd1, 14'h0000);
        nops(1);
        drive(ACT, 3'd1, 14'h0007);
        chk("trp err", 32'(err), 32'h08);
        clr();
        chk("bank_open b1 b2", 32'(bank_open), 32'h06);

        // WRITE to closed bank, auto-precharge timing
        drive(WR, 3'd0, 14'h0000);
        chk("wr closed err", 32'(err), 32'h02);
        chk("wr closed row_hit", 32'(row_hit), 32'h0);
        chk("wr cmd_code", 32'(cmd_code), 32'h3);
        clr();
        drive(ACT, 3'd0, 14'h0100);
        nops(2);
        drive(WR, 3'd0, 14'h0400);
        chk("wrap row_hit", 32'(row_hit), 32'h1);
        chk("wrap bank_open", 32'(bank_open), 32'h06);
        chk("wrap err", 32'(err), 32'h0);
        nops(3);
        drive(ACT, 3'd0, 14'h0100);
        chk("tap-1 err", 32'(err), 32'h08);
        clr();
        nops(1);
        drive(WR, 3'd0, 14'h0400);
        chk("wrap2 err", 32'(err), 32'h0);
        nops(4);
        drive(ACT, 3'd0, 14'h0100);
        chk("tap err", 32'(err), 32'h0);
        chk("tap bank_open", 32'(bank_open), 32'h07);

        // Refresh rules
        drive(ACT, 3'd3, 14'h0003);
        chk("act b3 bank_open", 32'(bank_open), 32'h0F);
        drive(REF, 3'd0, 14'h0000);
        chk("ref open err", 32'(err), 32'h10);
        chk("ref cmd_code", 32'(cmd_code), 32'h5);
        nops(25);
        clr();
        drive(PRE, 3'd0, 14'h0400);
        chk("pre all bank_open", 32'(bank_open), 32'h0);
        chk("pre all err", 32'(err), 32'h0);
        drive(REF, 3'd0, 14'h0000);
        chk("ref clean err", 32'(err), 32'h0);
        nops(24);
        drive(ACT, 3'd5, 14'h0005);
        chk("trfc-1 err", 32'(err), 32'h20);
        chk("trfc-1 bank_open", 32'(bank_open), 32'h20);
        clr();
        drive(PRE, 3'd5, 14'h0000);
        chk("pre b5 err", 32'(err), 32'h0);
        drive(REF, 3'd0, 14'h0000);
        nops(25);
        drive(ACT, 3'd6, 14'h0006);
        chk("trfc err", 32'(err), 32'h0);
        chk("trfc bank_open", 32'(bank_open), 32'h40);

        // Power-down ignores commands; reserved opcode
        cke = 1'b0;
        drive(ACT, 3'd7, 14'h0007);
        chk("cke0 cmd_valid", 32'(cmd_valid), 32'h0);
        chk("cke0 bank_open", 32'(bank_open), 32'h40);
        cke = 1'b1;
        drive(RSV, 3'd0, 14'h0000);
        chk("rsvd cmd_code", 32'(cmd_code), 32'h7);
        chk("rsvd err", 32'(err), 32'h20);

        // Reset mid-stream discards the sampled command
        rst = 1'b1;
        drive(ACT, 3'd4, 14'h0004);
        chk("mid rst bank_open", 32'(bank_open), 32'h0);
        chk("mid rst err", 32'(err), 32'h0);
        chk("mid rst cmd_valid", 32'(cmd_valid), 32'h0);
        chk("mid rst mr_valid", 32'(mr_valid), 32'h0);
        chk("mid rst row", 32'(bank_row[6*14 +: 14]), 32'h0);
        rst = 1'b0;
        drive(ACT, 3'd6, 14'h0006);
        chk("post rst err", 32'(err), 32'h0);
        chk("post rst bank_open", 32'(bank_open), 32'h40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ddr2_cmd_decoder.md
# ddr2_cmd_decoder

Synthesizable DDR2 command-bus receiver that sits on the device side of the controller's command interface (ck/cke/cs_n/ras_n/cas_n/we_n/ba/addr). It decodes each command, tracks per-bank open/closed state and open row, captures mode-register settings, and checks tRCD, tRP and tRFC timing plus bank-state protocol rules. It is the on-chip counterpart to ddr2_top's command generator, used in simulation and FPGA bring-up to confirm what the controller actually drives.

## Interface
- BA_BITS, 3, bank address width; NUM_BANKS = 2**BA_BITS
- ADDR_BITS, 14, row/column address width
- TRCD, 3, ACT to READ/WRITE same bank, in ck cycles
- TRP, 3, PRE to ACT same bank, in ck cycles
- TRFC, 26, REF to any non-NOP command, in ck cycles
- TAP, 5, auto-precharge close time (TRP + BL4/2), in ck cycles

- ck  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- cke, cs_n, ras_n, cas_n, we_n  in  1 each  DDR2 command pins
- ba  in  BA_BITS  bank address
- addr  in  ADDR_BITS  address bus
- err_clr  in  1  clears sticky errors
- cmd_valid  out  1  one-cycle pulse: decoded command present
- cmd_code  out  3  0 NOP, 1 ACT, 2 READ, 3 WRITE, 4 PRE, 5 REF, 6 LMR, 7 RSVD
- cmd_ba  out  BA_BITS  registered ba
- cmd_addr  out  ADDR_BITS  registered addr
- bank_open  out  NUM_BANKS  bit b = 1 while bank b holds an open row
- row_hit  out  1  with cmd_valid: READ/WRITE to an open bank
- mr_bl, mr_cl  out  3 each  MR0 addr[2:0] and addr[6:4]
- mr_valid  out  1  MR0 loaded at least once since reset
- err  out  6  sticky: [0] ACT to open bank, [1] RD/WR to closed bank, [2] tRCD, [3] tRP, [4] REF with any bank open, [5] RSVD command or non-NOP inside tRFC

## Operation
- Sample only when cke = 1. With cke = 0, emit nothing and change no state; counters keep decrementing.
- cs_n = 1 is DESELECT: no cmd_valid.
- With cs_n = 0, decode {ras_n,cas_n,we_n}: 000 LMR, 001 REF, 010 PRE, 011 ACT, 100 WRITE, 101 READ, 110 RSVD, 111 NOP. NOP does not assert cmd_valid.
- ACT: set bank_open[ba] and store row = addr in the per-bank row register. Load trcd_cnt[ba] = TRCD-1. Check err[0] and err[3] (trp_cnt[ba] != 0).
- READ/WRITE: check err[1] if the bank is closed, and err[2] if trcd_cnt[ba] != 0. row_hit = bank_open[ba]. If addr[10] = 1 (auto-precharge), clear bank_open[ba] and load trp_cnt[ba] = TAP-1.
- PRE: if addr[10] = 1, act on all banks; otherwise act on bank ba. Clear bank_open and load trp_cnt = TRP-1, for open banks only. PRE to a closed bank is legal and is a no-op.
- REF: check err[4] if any bank is open. Load trfc_cnt = TRFC-1.
- LMR: only when ba = 0, capture mr_bl and mr_cl and set mr_valid. EMR1/2/3 are decoded but not stored.
- Any cmd_valid command while trfc_cnt != 0 sets err[5], and so does RSVD. The command is still applied to bank state.
- Counters decrement toward 0, saturating at 0.
- err bits are sticky. Setting a bit has priority over err_clr in the same cycle.
- rst: clear all outputs to 0, all bank_open, all row registers, all counters, and mr_*.

## Timing
- Latency is 1 cycle: a command sampled at edge n appears on cmd_*, row_hit and err at cycle n+1.
- bank_open updates at cycle n+1.
- The err bit for a violating command rises at n+1.
- ACT at edge 0: READ at edge TRCD is legal; READ at edge TRCD-1 sets err[2].
- The same rule applies to PRE→ACT with TRP, AP→ACT with TAP, and REF→any with TRFC.
- Back-to-back commands on consecutive edges are all decoded, with no bubbles.
- Same-edge ACT after a prior PRE to the same bank uses the counter value before that edge.
- rst asserted mid-sequence forces reset state on the next edge. A command sampled on that edge is discarded.

## Test plan
- Reset then NOPs: all outputs 0, cmd_valid never asserts.
- LMR ba=0, addr=0x0032 → cmd_code 6, mr_bl=2, mr_cl=3, mr_valid=1; LMR ba=1 leaves mr_* unchanged.
- ACT b2 row 0x1A5, then READ b2 at +3 cycles → bank_open=0x04, row_hit=1, err=0. Repeat with READ at +2 → err[2]=1.
- ACT b1, ACT b1 again → err[0]. PRE b1 then ACT b1 at +2 → err[3]. Assert err_clr → err=0.
- WRITE b0 to a closed bank → err[1], row_hit=0. ACT b0, WRITE with addr[10]=1 → bank_open[0] clears at n+1; ACT b0 at +4 → err[3], at +5 → clean.
- REF with b3 open → err[4]. PRE-all, REF, then ACT at +25 → err[5], at +26 → clean. Hold cke=0 during an ACT → ignored. Assert rst mid-stream → all state cleared.
